// File: rtl/yutorina_bus_arbiter_mux.sv
// yutorina_bus_arbiter_mux: round-robin bus arbiter with active-low grants fused with the master-to-slave bus mux
module yutorina_bus_arbiter_mux #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 0,
  parameter bit REG_OUT = 1'b0,
  localparam int OW = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        m_req_,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS-1:0]        m_as_,
  input  logic [N_MASTERS-1:0]        m_rw,
  input  logic [N_MASTERS*DATA_W-1:0] m_w_data,
  output logic [N_MASTERS-1:0]        m_grnt_,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_as_,
  output logic                        s_rw,
  output logic [DATA_W-1:0]           s_w_data,
  output logic [OW-1:0]               owner,
  output logic                        busy
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam bit HOLD_EN = MAX_HOLD > 0;
  logic [OW-1:0] last, sel;
  logic [HW-1:0] cnt;
  logic [N_MASTERS-1:0] mask, req, rot;
  logic [2*N_MASTERS-1:0] dbl;
  logic [OW:0] pos, sum;
  logic found, revoke;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic as_c, rw_c;
  // The holder is masked out, so a releasing or revoked master ranks last behind everyone else
  always_comb begin
    mask = busy ? N_MASTERS'(1) << owner : '0;
    req = ~m_req_ & ~mask;
    dbl = {req, req} >> ({1'b0, busy ? owner : last} + (OW+1)'(1));
    rot = dbl[N_MASTERS-1:0];
    found = |rot;
    pos = '0;
    for (int j = N_MASTERS - 1; j >= 0; j--) pos = rot[j] ? (OW+1)'(j) : pos;
    sum = {1'b0, busy ? owner : last} + pos + (OW+1)'(1);
    sel = OW'(sum >= (OW+1)'(N_MASTERS) ? sum - (OW+1)'(N_MASTERS) : sum);
    revoke = HOLD_EN && cnt == HOLD_MAX && found && m_as_[owner];
    m_grnt_ = ~mask;
    addr_c = busy ? m_addr[owner*ADDR_W +: ADDR_W] : '0;
    data_c = busy ? m_w_data[owner*DATA_W +: DATA_W] : '0;
    as_c = busy ? m_as_[owner] : 1'b1;
    rw_c = busy ? m_rw[owner] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      owner <= '0;
      last <= OW'(N_MASTERS - 1);
      cnt <= '0;
    end else if (!busy) begin
      busy <= found;
      owner <= found ? sel : owner;
      cnt <= '0;
    end else if (m_req_[owner] || revoke) begin
      last <= owner;
      busy <= found;
      owner <= found ? sel : owner;
      cnt <= '0;
    end else begin
      cnt <= cnt == HOLD_MAX ? cnt : cnt + HW'(1);
    end
  end
  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          s_addr <= '0;
          s_as_ <= 1'b1;
          s_rw <= 1'b1;
          s_w_data <= '0;
        end else begin
          s_addr <= addr_c;
          s_as_ <= as_c;
          s_rw <= rw_c;
          s_w_data <= data_c;
        end
      end
    end else begin : g_comb
      always_comb begin
        s_addr = addr_c;
        s_as_ = as_c;
        s_rw = rw_c;
        s_w_data = data_c;
      end
    end
  endgenerate
endmodule

// File: tb/tb_yutorina_bus_arbiter_mux.sv
// tb_yutorina_bus_arbiter_mux: directed vectors on a combinational/unlimited instance (a) and a registered/hold-limited instance (b)
module tb_yutorina_bus_arbiter_mux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] m_req_ = 4'hf, m_as_ = 4'hf, m_rw = 4'hf;
  logic [119:0] m_addr;
  logic [127:0] m_w_data;
  logic [3:0] grnt_a, grnt_b;
  logic [29:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic as_a, as_b, rw_a, rw_b, busy_a, busy_b;
  logic [1:0] owner_a, owner_b;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  yutorina_bus_arbiter_mux #(.N_MASTERS(4), .ADDR_W(30), .DATA_W(32), .MAX_HOLD(0), .REG_OUT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_w_data(m_w_data), .m_grnt_(grnt_a), .s_addr(addr_a), .s_as_(as_a), .s_rw(rw_a),
    .s_w_data(data_a), .owner(owner_a), .busy(busy_a));
  yutorina_bus_arbiter_mux #(.N_MASTERS(4), .ADDR_W(30), .DATA_W(32), .MAX_HOLD(4), .REG_OUT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_w_data(m_w_data), .m_grnt_(grnt_b), .s_addr(addr_b), .s_as_(as_b), .s_rw(rw_b),
    .s_w_data(data_b), .owner(owner_b), .busy(busy_b));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot_a", 64'($countones(~grnt_a) <= 1), 64'd1);
    check("onehot_b", 64'($countones(~grnt_b) <= 1), 64'd1);
  endtask
  task automatic run_rr(input string tag);
    logic [3:0] e;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 3; c++) begin
        tick();
        e = ~(4'b0001 << k);
        check($sformatf("%s_grnt_a_m%0d_c%0d", tag, k, c), grnt_a, e);
        check($sformatf("%s_grnt_b_m%0d_c%0d", tag, k, c), grnt_b, e);
        if (c == 2) m_req_[k] = 1'b1;
      end
    tick();
    check({tag, "_idle_a"}, busy_a, 1'b0);
    check({tag, "_idle_b"}, busy_b, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i*30 +: 30] = 30'h100 + 30'(i);
      m_w_data[i*32 +: 32] = 32'hcafe_0000 + 32'(i);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t1_grnt_a", grnt_a, 4'hf);
    check("t1_grnt_b", grnt_b, 4'hf);
    check("t1_busy", busy_a, 1'b0);
    check("t1_owner", owner_a, 2'd0);
    check("t1_as_a", as_a, 1'b1);
    check("t1_as_b", as_b, 1'b1);
    check("t1_rw", rw_a, 1'b1);
    check("t1_addr", addr_a, 30'h0);
    check("t1_data", data_a, 32'h0);
    m_addr[60 +: 30] = 30'h1234;
    m_as_[2] = 1'b0;
    m_rw[2] = 1'b0;
    m_req_ = 4'b1011;
    tick();
    check("t2_grnt_a", grnt_a, 4'b1011);
    check("t2_grnt_b", grnt_b, 4'b1011);
    check("t2_owner", owner_a, 2'd2);
    check("t2_busy", busy_a, 1'b1);
    check("t2_addr_a", addr_a, 30'h1234);
    check("t2_as_a", as_a, 1'b0);
    check("t2_rw_a", rw_a, 1'b0);
    check("t2_data_a", data_a, 32'hcafe_0002);
    check("t2_as_b_early", as_b, 1'b1);
    check("t2_addr_b_early", addr_b, 30'h0);
    tick();
    check("t2_as_b", as_b, 1'b0);
    check("t2_addr_b", addr_b, 30'h1234);
    check("t2_rw_b", rw_b, 1'b0);
    m_req_ = 4'hf;
    m_as_ = 4'hf;
    m_rw = 4'hf;
    tick();
    check("t2_rel_grnt", grnt_a, 4'hf);
    check("t2_rel_as_a", as_a, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_req_ = 4'b0000;
    run_rr("t3");
    m_req_ = 4'b1011;
    tick();
    check("t4_own_a", owner_a, 2'd2);
    m_req_ = 4'b0010;
    tick();
    check("t4_keep_a", owner_a, 2'd2);
    m_req_ = 4'b0110;
    tick();
    check("t4_next_a", grnt_a, 4'b0111);
    check("t4_next_b", grnt_b, 4'b0111);
    check("t4_owner_b", owner_b, 2'd3);
    m_req_ = 4'hf;
    tick();
    m_req_ = 4'b1110;
    m_as_[0] = 1'b0;
    tick();
    check("t5_grant_b", owner_b, 2'd0);
    m_req_ = 4'b1100;
    foreach (m_as_[i]) if (i == 0) m_as_[i] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      m_as_[0] = (e == 1 || e == 3 || e == 6);
      tick();
      check($sformatf("t5_b_e%0d", e), owner_b, e == 6 ? 2'd1 : 2'd0);
      check($sformatf("t5_a_e%0d", e), owner_a, 2'd0);
    end
    check("t5_revoked_grnt_b", grnt_b, 4'b1101);
    m_req_ = 4'hf;
    m_as_ = 4'hf;
    tick();
    m_req_ = 4'b1101;
    m_as_[1] = 1'b0;
    m_rw[1] = 1'b0;
    tick();
    check("t6_own_a", owner_a, 2'd1);
    check("t6_own_b", owner_b, 2'd1);
    check("t6_as_a", as_a, 1'b0);
    tick();
    check("t6_as_b", as_b, 1'b0);
    reset = 1'b1;
    tick();
    check("t6_rst_grnt_a", grnt_a, 4'hf);
    check("t6_rst_grnt_b", grnt_b, 4'hf);
    check("t6_rst_busy_a", busy_a, 1'b0);
    check("t6_rst_as_a", as_a, 1'b1);
    check("t6_rst_as_b", as_b, 1'b1);
    check("t6_rst_rw_b", rw_b, 1'b1);
    check("t6_rst_addr_b", addr_b, 30'h0);
    reset = 1'b0;
    m_as_ = 4'hf;
    m_rw = 4'hf;
    m_req_ = 4'b0000;
    run_rr("t6");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
